// File: rtl/pmu_mem_bank.sv
// pmu_mem_bank: parametrised single-port PMU storage bank with byte
// enables, registered read response and a hardware zero-fill engine.
module pmu_mem_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    input  logic                  clear_i,
    output logic                  busy_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic                last;
    logic                accept;
    logic                rd_accept;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign last      = (cnt == {ADDR_W{1'b1}});
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;

    // State register; reset always restarts the zero-fill
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; clear_i is ignored while clearing
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy_o    = 1'b0;
        unique case (state)
            CLEAR: begin
                busy_o = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                req_ready = !clear_i;
                if (clear_i) begin
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Clear counter walks every word once, wrapping back to 0 at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Single write port: zero-fill while clearing, byte-masked writes otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (accept && req_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (req_be[b]) begin
                        mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Registered read response; data holds while no read is returning
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_accept;
            if (rd_accept) begin
                rsp_rdata <= mem[req_addr];
            end
        end
    end

endmodule

// File: tb/tb_pmu_mem_bank.sv
// tb_pmu_mem_bank: directed self-checking bench for pmu_mem_bank
// with default 32-bit x 256-word geometry.
module tb_pmu_mem_bank;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        clear_i;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    pmu_mem_bank #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .clear_i   (clear_i),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string what);
        int t;
        t = 0;
        while (!req_ready && t < 1000) begin
            tick();
            t++;
        end
        if (t >= 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: req_ready still %0b, required 1", what, req_ready);
        end
    endtask

    task automatic issue_write(input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        wait_ready("write");
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic issue_read(input logic [7:0] a, output logic v,
                              output logic [31:0] d);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        wait_ready("read");
        tick();
        v = rsp_valid;
        d = rsp_rdata;
        req_valid = 1'b0;
    endtask

    task automatic fill_pattern();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'hF;
        for (int i = 0; i < 256; i++) begin
            req_addr  = 8'(i);
            req_wdata = 32'(i) * 32'h0101_0101;
            tick();
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy_o && cyc < 1000) begin
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        int          cyc;
        logic        v;
        logic [31:0] d;
        logic [7:0]  addrs [3];
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (req_ready !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hs: ready=%b busy=%b, required 0/1", req_ready, busy_o);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rsp: valid=%b data=%h, required 0/0", rsp_valid, rsp_rdata);
        end
        rst = 1'b0;
        count_busy(cyc);
        n_cmp++;
        if (cyc !== 256) begin
            n_err++;
            $display("FAIL reset_busy_len: got %0d cycles, required 256", cyc);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
        addrs[0] = 8'h00;
        addrs[1] = 8'h7F;
        addrs[2] = 8'hFF;
        foreach (addrs[k]) begin
            issue_read(addrs[k], v, d);
            n_cmp++;
            if (v !== 1'b1 || d !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read_%h: valid=%b data=%h, required 1/00000000",
                         addrs[k], v, d);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic        v;
        logic [31:0] d;
        issue_write(8'h10, 32'hAABB_CCDD, 4'hF);
        issue_write(8'h10, 32'h1122_3344, 4'h5);
        issue_read(8'h10, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'hAA22_CC44) begin
            n_err++;
            $display("FAIL be_read: valid=%b data=%h, required 1/aa22cc44", v, d);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hAA22_CC44) begin
            n_err++;
            $display("FAIL be_pulse: valid=%b data=%h, required 0/aa22cc44 held",
                     rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        fill_pattern();
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            req_addr = 8'(i);
            tick();
            if (rsp_valid !== 1'b1 || req_ready !== 1'b1 ||
                rsp_rdata !== 32'(i) * 32'h0101_0101) begin
                bad++;
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL stream: %0d bad cycles, required 0", bad);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_write_then_read();
        logic        v;
        logic [31:0] d;
        issue_write(8'h05, 32'hDEAD_BEEF, 4'hF);
        issue_read(8'h05, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL wr_rd: valid=%b data=%h, required 1/deadbeef", v, d);
        end
    endtask

    task automatic test_cmd_clear();
        int cyc;
        int early;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h05;
        tick();
        clear_i = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL clr_inflight: valid=%b data=%h, required 1/deadbeef",
                     rsp_valid, rsp_rdata);
        end
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ready: got %b, required 0", req_ready);
        end
        cyc   = 1;
        early = 0;
        tick();
        clear_i = 1'b0;
        while (!req_ready && cyc < 1000) begin
            if (rsp_valid !== 1'b0) early++;
            cyc++;
            tick();
        end
        n_cmp++;
        if (cyc !== 257 || early !== 0) begin
            n_err++;
            $display("FAIL clr_len: %0d blocked cycles, %0d stray rsp, required 257/0",
                     cyc, early);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL clr_read: valid=%b data=%h, required 1/00000000",
                     rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        int bad;
        fill_pattern();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(cyc);
        n_cmp++;
        if (cyc !== 256) begin
            n_err++;
            $display("FAIL rmc_busy_len: got %0d cycles, required 256", cyc);
        end
        bad = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            req_addr = 8'(i);
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) bad++;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rmc_readback: %0d nonzero words, required 0", bad);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 8'h00;
        req_wdata = 32'h0;
        clear_i   = 1'b0;
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_write_then_read();
        test_cmd_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pmu_mem_bank.md
# pmu_mem_bank

Parametrised single-port PMU storage bank that replaces the fixed 256x32 PMU memory. It adds configurable width and depth, per-byte write enables, a valid/ready request port, a registered read response, and a hardware clear engine that zero-fills the array after reset or on command, so the array needs no simulation-only initial block. It sits between the PMU controller and its working storage; one request is serviced per cycle when the bank is idle.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W words.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  DATA_W/8  byte write enables; ignored for reads.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid; one-cycle pulse per accepted read.
- rsp_rdata  out  DATA_W  read data; holds its last value when rsp_valid = 0.
- clear_i  in  1  request a full zero-fill of the array.
- busy_o  out  1  clear in progress.

## Operation
- Two states: CLEAR and IDLE. A request is accepted when req_valid && req_ready.
- rst = 1: state = CLEAR, clear counter = 0, rsp_valid = 0, rsp_rdata = 0. Array contents are not touched while rst is high.
- CLEAR (rst = 0): each cycle writes mem[cnt] = 0 and increments cnt. After the cycle that writes cnt = DEPTH-1, the next state is IDLE and cnt returns to 0.
- CLEAR outputs: req_ready = 0, busy_o = 1. clear_i is ignored and does not restart the count.
- IDLE: busy_o = 0 and req_ready = !clear_i. clear_i = 1 moves the bank to CLEAR on the next edge; no request is accepted in that cycle.
- Write: for each byte b with req_be[b] = 1, mem[req_addr][8b+7:8b] takes req_wdata[8b+7:8b]. Other bytes are unchanged. req_be = 0 performs no write but is still accepted. Writes produce no response.
- Read: registers mem[req_addr] into rsp_rdata and asserts rsp_valid in the following cycle.
- A response already in flight when clear_i is asserted is delivered with the pre-clear data.
- Addresses use the full ADDR_W range; no out-of-range case exists.

## Timing
- Reset values: req_ready = 0, busy_o = 1, rsp_valid = 0, rsp_rdata = 0.
- After rst falls, the first rising edge with rst = 0 is edge 0. Edges 0 through DEPTH-1 perform the clear writes. req_ready = 1 and busy_o = 0 from the cycle after edge DEPTH-1. This is DEPTH cycles of busy after release; 256 for the default ADDR_W.
- Read latency: accepted at edge N, so rsp_valid = 1 and rsp_rdata is valid in the cycle after edge N. rsp_valid drops after edge N+1 unless another read is accepted at N+1.
- Back-to-back reads sustain one response per cycle.
- A read accepted the cycle after a write to the same address returns the newly written data.
- Command clear: clear_i sampled high at edge N (state IDLE) puts the bank in CLEAR from edge N. The zero writes land at edges N+1 through N+DEPTH, and req_ready returns after edge N+DEPTH.
- rst asserted mid-clear: the count restarts at 0 and the full DEPTH-cycle clear repeats after release.
- rst asserted with a read in flight: rsp_valid = 0 from the next edge and the response is dropped.

## Test plan
- Reset release with defaults: busy_o = 1 and req_ready = 0 for exactly 256 cycles, then req_ready = 1. Reads of addresses 0x00, 0x7F and 0xFF return 0x00000000.
- Byte-enable write: write 0xAABBCCDD to 0x10 with be = 0xF, then write 0x11223344 with be = 0x5. Read of 0x10 returns 0xAA22CC44 with rsp_valid exactly one cycle after acceptance.
- Streaming: after writing addr i = i*0x01010101 for all i, issue 256 back-to-back reads. The bench sees 256 consecutive rsp_valid cycles with matching data and req_ready held at 1.
- Write then read: write 0xDEADBEEF to 0x05, then read 0x05 on the next cycle. Response is 0xDEADBEEF.
- Command clear: issue a read of 0x05, then raise clear_i the next cycle with req_valid held high. The read still returns 0xDEADBEEF; no request is accepted for 257 cycles; a subsequent read of 0x05 returns 0.
- Reset mid-clear: assert rst for 1 cycle, 100 cycles into a clear. busy_o then stays high for a further 256 cycles after release, and the final readback is all zeros.
